// File: rtl/axis_hdr_insert_arbiter.sv
// Packet-level round-robin arbiter feeding one header-insert datapath.
// Optional stall watchdog enabled by defining HDR_ARB_STALL_WDOG_EN.
module axis_hdr_insert_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int ID_WD        = $clog2(NUM_SRC),
    parameter int MAX_STALL    = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC-1:0]              s_valid_hdr,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_header,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_hdr,
    output logic [NUM_SRC-1:0]              s_ready_hdr,
    input  logic [NUM_SRC-1:0]              s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]      s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in,
    input  logic [NUM_SRC-1:0]              s_last_in,
    output logic [NUM_SRC-1:0]              s_ready_in,
    output logic                            m_valid_insert,
    output logic [DATA_WD-1:0]              m_header_insert,
    output logic [DATA_BYTE_WD-1:0]         m_keep_insert,
    input  logic                            m_ready_insert,
    output logic                            m_valid_in,
    output logic [DATA_WD-1:0]              m_data_in,
    output logic [DATA_BYTE_WD-1:0]         m_keep_in,
    output logic                            m_last_in,
    input  logic                            m_ready_in,
    output logic [ID_WD-1:0]                grant_id,
    output logic                            busy,
    output logic                            err_stall
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]       state;
    logic [ID_WD-1:0] rr_ptr;
    logic [ID_WD-1:0] pick;
    logic [ID_WD-1:0] next_ptr;
    logic             pick_vld;
    logic             hdr_hs;
    logic             dat_hs;
    int               idx;

    // Scan downward so the source closest to rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (s_valid_hdr[ID_WD'(idx)]) begin
                pick     = ID_WD'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_id == ID_WD'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

    assign m_valid_insert = (state == HDR) & s_valid_hdr[grant_id];
    assign m_valid_in     = (state == DATA) & s_valid_in[grant_id];
    assign hdr_hs         = m_valid_insert & m_ready_insert;
    assign dat_hs         = m_valid_in & m_ready_in;
    assign busy           = (state != IDLE);

    always_comb begin
        m_header_insert = '0;
        m_keep_insert   = '0;
        m_data_in       = '0;
        m_keep_in       = '0;
        m_last_in       = 1'b0;
        if (m_valid_insert) begin
            m_header_insert = s_header[int'(grant_id)*DATA_WD +: DATA_WD];
            m_keep_insert   = s_keep_hdr[int'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
        end
        if (m_valid_in) begin
            m_data_in = s_data_in[int'(grant_id)*DATA_WD +: DATA_WD];
            m_keep_in = s_keep_in[int'(grant_id)*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_last_in = s_last_in[grant_id];
        end
    end

    // Ready depends only on state, grant and downstream ready.
    always_comb begin
        s_ready_hdr = '0;
        s_ready_in  = '0;
        if (state == HDR)  s_ready_hdr[grant_id] = m_ready_insert;
        if (state == DATA) s_ready_in[grant_id]  = m_ready_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_hs) state <= DATA;
                end
                DATA: begin
                    if (dat_hs && m_last_in) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HDR_ARB_STALL_WDOG_EN
    logic [15:0] stall_cnt;
    logic        err_q;
    logic        stall_cyc;

    assign stall_cyc = (state == DATA) & ~s_valid_in[grant_id];
    assign err_stall = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            if (!stall_cyc) begin
                stall_cnt <= '0;
            end else if (stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
                if (stall_cnt == 16'(MAX_STALL - 1)) err_q <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (MAX_STALL != 0);
    assign err_stall   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Scoreboard bench for axis_hdr_insert_arbiter: random packets from
// 4 sources, round-robin order predicted from pending-request sets.
module tb_axis_hdr_insert_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int K = 4;

    typedef struct packed {
        logic [31:0]      hdr;
        logic [3:0]       hk;
        logic [3:0]       n;
        logic [7:0][31:0] d;
        logic [7:0][3:0]  k;
    } pkt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   s_valid_hdr, s_ready_hdr, s_valid_in, s_last_in, s_ready_in;
    logic [N*W-1:0] s_header, s_data_in;
    logic [N*K-1:0] s_keep_hdr, s_keep_in;
    logic           m_valid_insert, m_ready_insert, m_valid_in, m_last_in, m_ready_in;
    logic [W-1:0]   m_header_insert, m_data_in;
    logic [K-1:0]   m_keep_insert, m_keep_in;
    logic [1:0]     grant_id;
    logic           busy, err_stall;

    axis_hdr_insert_arbiter #(
        .NUM_SRC(N), .DATA_WD(W), .DATA_BYTE_WD(K), .ID_WD(2), .MAX_STALL(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid_hdr(s_valid_hdr), .s_header(s_header),
        .s_keep_hdr(s_keep_hdr), .s_ready_hdr(s_ready_hdr),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in),
        .s_keep_in(s_keep_in), .s_last_in(s_last_in),
        .s_ready_in(s_ready_in),
        .m_valid_insert(m_valid_insert), .m_header_insert(m_header_insert),
        .m_keep_insert(m_keep_insert), .m_ready_insert(m_ready_insert),
        .m_valid_in(m_valid_in), .m_data_in(m_data_in),
        .m_keep_in(m_keep_in), .m_last_in(m_last_in),
        .m_ready_in(m_ready_in),
        .grant_id(grant_id), .busy(busy), .err_stall(err_stall)
    );

    pkt_t drv_q [N][$];
    pkt_t exp_q [N][$];

    int vecs = 0;
    int errs = 0;
    int pend [N];
    int rr_m = 0;
    int cur = 0;
    int beat = 0;
    int hold_ins = 0;
    bit in_data = 1'b0;
    bit just_done = 1'b0;
    bit mon_en = 1'b0;
    int drv_phase [N];
    int drv_bi [N];
    logic [N-1:0] hdr_hs_f = '0;
    logic [N-1:0] dat_hs_f = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Next grant: first source with outstanding packets, from rr pointer.
    function automatic int pick_model();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr_m + k) % N] > 0) return (rr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic int pend_total();
        int t = 0;
        for (int i = 0; i < N; i++) t += pend[i];
        return t;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            pkt_t p;
            int   es;
            hdr_hs_f = s_valid_hdr & s_ready_hdr;
            dat_hs_f = s_valid_in & s_ready_in;
`ifndef HDR_ARB_STALL_WDOG_EN
            chk("err_stall_off", err_stall, 0);
`endif
            if (!m_valid_insert) chk("hdr_mux_zero", {m_header_insert, m_keep_insert}, 0);
            if (!m_valid_in) chk("dat_mux_zero", {m_data_in, m_keep_in, m_last_in}, 0);
            if (just_done) begin
                chk("idle_busy", busy, 0);
                chk("idle_no_hdr", m_valid_insert, 0);
                just_done = 1'b0;
            end
            if (in_data) begin
                chk("ready_in_gnt", s_ready_in, m_ready_in ? (64'd1 << cur) : 64'd0);
                chk("hdr_quiet", {m_valid_insert, s_ready_hdr}, 0);
                chk("grant_id_data", grant_id, cur);
            end else begin
                chk("ready_in_off", s_ready_in, 0);
                chk("valid_in_off", m_valid_in, 0);
                if (!m_ready_insert) chk("ready_hdr_off", s_ready_hdr, 0);
            end
            if (m_valid_in && m_ready_in) begin
                chk("stray_beat", in_data, 1);
                if (in_data) begin
                    p = exp_q[cur][0];
                    chk("data", m_data_in, p.d[beat]);
                    chk("keep", m_keep_in, p.k[beat]);
                    chk("last", m_last_in, (beat == int'(p.n) - 1));
                    if (beat == int'(p.n) - 1) begin
                        void'(exp_q[cur].pop_front());
                        pend[cur]--;
                        rr_m = (cur + 1) % N;
                        in_data = 1'b0;
                        just_done = 1'b1;
                    end else begin
                        beat++;
                    end
                end
            end else if (m_valid_insert && m_ready_insert) begin
                es = pick_model();
                chk("hdr_expected", es >= 0, 1);
                if (es >= 0) begin
                    p = exp_q[es][0];
                    chk("grant_src", s_ready_hdr, 64'd1 << es);
                    chk("grant_id_hdr", grant_id, es);
                    chk("header", m_header_insert, p.hdr);
                    chk("hdr_keep", m_keep_insert, p.hk);
                    in_data = 1'b1;
                    cur = es;
                    beat = 0;
                end
            end
        end
    end

    // Source and sink drivers
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                drv_phase[i] = 0;
                drv_bi[i] = 0;
            end
            s_valid_hdr = '0;
            s_valid_in = '0;
            s_last_in = '0;
            s_header = '0;
            s_keep_hdr = '0;
            s_data_in = '0;
            s_keep_in = '0;
            m_ready_insert = 1'b0;
            m_ready_in = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                pkt_t p;
                if (hdr_hs_f[i]) begin
                    drv_phase[i] = 1;
                    drv_bi[i] = 0;
                end else if (dat_hs_f[i] && drv_phase[i] == 1) begin
                    if (drv_bi[i] == int'(drv_q[i][0].n) - 1) begin
                        void'(drv_q[i].pop_front());
                        drv_phase[i] = 0;
                    end else begin
                        drv_bi[i]++;
                    end
                end
                if (drv_phase[i] == 0 && drv_q[i].size() > 0) begin
                    p = drv_q[i][0];
                    s_valid_hdr[i] = 1'b1;
                    s_header[i*W +: W] = p.hdr;
                    s_keep_hdr[i*K +: K] = p.hk;
                end else begin
                    s_valid_hdr[i] = 1'b0;
                    s_header[i*W +: W] = $urandom;
                    s_keep_hdr[i*K +: K] = 4'($urandom);
                end
                if (drv_phase[i] == 1) begin
                    p = drv_q[i][0];
                    s_valid_in[i] = ($urandom_range(0, 3) != 0);
                    s_data_in[i*W +: W] = p.d[drv_bi[i]];
                    s_keep_in[i*K +: K] = p.k[drv_bi[i]];
                    s_last_in[i] = (drv_bi[i] == int'(p.n) - 1);
                end else begin
                    // Data offered without an accepted header must be ignored.
                    s_valid_in[i] = ($urandom_range(0, 2) == 0);
                    s_data_in[i*W +: W] = $urandom;
                    s_keep_in[i*K +: K] = 4'($urandom);
                    s_last_in[i] = 1'($urandom);
                end
            end
            hdr_hs_f = '0;
            dat_hs_f = '0;
            if (hold_ins > 0) begin
                m_ready_insert = 1'b0;
                hold_ins--;
            end else begin
                m_ready_insert = ($urandom_range(0, 2) != 0);
            end
            m_ready_in = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic issue(input int src, input int n, input logic [31:0] hdr, input logic [3:0] hk);
        pkt_t p;
        p = '0;
        p.hdr = hdr;
        p.hk = hk;
        p.n = 4'(n);
        for (int b = 0; b < 8; b++) begin
            p.d[b] = $urandom;
            p.k[b] = 4'($urandom);
        end
        drv_q[src].push_back(p);
        exp_q[src].push_back(p);
        pend[src]++;
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while ((pend_total() > 0 || in_data) && c < bound) begin
            @(posedge clk);
            c++;
        end
        chk("drain_timeout", pend_total(), 0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {m_valid_insert, m_valid_in, s_ready_hdr, s_ready_in,
                 busy, grant_id, err_stall, m_header_insert, m_data_in}, 0);
    endtask

    initial begin
        int c;
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Lone src1, 3-beat packet, header held off for 5 cycles
        issue(1, 3, 32'hA5A5A5A5, 4'b0011);
        hold_ins = 6;
        drain(2000);

        // rr pointer now 2: src3 must beat src1
        issue(1, 2, $urandom, 4'hF);
        issue(3, 2, $urandom, 4'hF);
        drain(2000);

        // Everyone requesting continuously
        for (int i = 0; i < N; i++) begin
            issue(i, 2, $urandom, 4'($urandom));
            issue(i, 2, $urandom, 4'($urandom));
        end
        drain(4000);

        for (int t = 0; t < 25; t++) begin
            int tot = 0;
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 2);
                for (int j = 0; j < np; j++)
                    issue(i, $urandom_range(1, 4), $urandom, 4'($urandom));
                tot += np;
            end
            if (tot == 0) issue($urandom_range(0, N - 1), 1, $urandom, 4'($urandom));
            drain(4000);
        end

        // Asynchronous reset in the middle of a packet
        for (int i = 0; i < N; i++) issue(i, 6, $urandom, 4'($urandom));
        c = 0;
        while (!in_data && c < 200) begin
            @(posedge clk);
            c++;
        end
        chk("wait_data", in_data, 1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            pend[i] = 0;
        end
        rr_m = 0;
        in_data = 1'b0;
        just_done = 1'b0;
        @(posedge clk);
        #2;
        chk_all_zero("reset_held");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // rr pointer back at 0: src0 before src2
        issue(2, 2, $urandom, 4'($urandom));
        issue(0, 1, $urandom, 4'($urandom));
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
